// File: rtl/montgomery_exp_ctrl_pkg.sv
// Shared definitions for the modular-exponentiation sequencer: state encoding
// and default widths.
package montgomery_exp_ctrl_pkg;

   localparam int N_DEFAULT   = 512;
   localparam int E_W_DEFAULT = 512;

   typedef enum logic [3:0] {
      IDLE,
      PRE_GO,
      PRE_WAIT,
      SQR_GO,
      SQR_WAIT,
      MUL_GO,
      MUL_WAIT,
      POST_GO,
      POST_WAIT,
      DONE
   } state_t;

   function automatic logic is_go(input state_t s);
      return (s inside {PRE_GO, SQR_GO, MUL_GO, POST_GO});
   endfunction

endpackage

// File: rtl/montgomery_exp_ctrl_exp_bit_scanner.sv
// Latched exponent walker: presents e[i] from the top processed bit down to
// bit 0, with a flag for the last bit and one for an empty exponent.
module exp_bit_scanner
   import montgomery_exp_ctrl_pkg::*;
#(
   parameter int E_W = E_W_DEFAULT,
   parameter int LW  = $clog2(E_W + 1)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           load,
   input  logic           dec,
   input  logic [E_W-1:0] e,
   input  logic [LW-1:0]  elen,
   output logic           cur_bit,
   output logic           last,
   output logic           empty
);

   localparam logic [LW-1:0] MAX_LEN = LW'(E_W);

   logic [E_W-1:0] e_q;
   logic [LW-1:0]  idx_q;
   logic           empty_q;
   logic [LW-1:0]  len_clamped;

   // Lengths beyond the exponent register are treated as the full width.
   assign len_clamped = (elen > MAX_LEN) ? MAX_LEN : elen;

   always_ff @(posedge clk) begin
      if (reset) begin
         e_q     <= '0;
         idx_q   <= '0;
         empty_q <= 1'b1;
      end else if (load) begin
         e_q     <= e;
         idx_q   <= (len_clamped == '0) ? '0 : len_clamped - LW'(1);
         empty_q <= (len_clamped == '0);
      end else if (dec && (idx_q != '0)) begin
         idx_q <= idx_q - LW'(1);
      end
   end

   assign cur_bit = |(e_q & (E_W'(1) << idx_q));
   assign last    = (idx_q == '0);
   assign empty   = empty_q;

endmodule

// File: rtl/montgomery_exp_ctrl.sv
// Sequencer for x^e mod m: Montgomery entry, left-to-right square-and-multiply,
// and exit, driving one shared external Montgomery multiplier.
module montgomery_exp_ctrl
   import montgomery_exp_ctrl_pkg::*;
#(
   parameter int N   = N_DEFAULT,
   parameter int E_W = E_W_DEFAULT,
   parameter int LW  = $clog2(E_W + 1)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [N-1:0]   in_x,
   input  logic [E_W-1:0] in_e,
   input  logic [LW-1:0]  in_elen,
   input  logic [N-1:0]   in_m,
   input  logic [N-1:0]   in_r,
   input  logic [N-1:0]   in_r2,
   output logic           busy,
   output logic           done,
   output logic [N-1:0]   result,
   output logic           mm_start,
   output logic [N-1:0]   mm_a,
   output logic [N-1:0]   mm_b,
   output logic [N-1:0]   mm_m,
   input  logic [N-1:0]   mm_result,
   input  logic           mm_done
);

   localparam logic [N-1:0] ONE = N'(1);

   state_t       state, state_next;
   logic [N-1:0] x_q, m_q, r2_q, xm_q, acc_q, result_q;
   logic         scan_load, scan_dec, scan_bit, scan_last, scan_empty;

   exp_bit_scanner #(
      .E_W (E_W),
      .LW  (LW)
   ) u_scanner (
      .clk     (clk),
      .reset   (reset),
      .load    (scan_load),
      .dec     (scan_dec),
      .e       (in_e),
      .elen    (in_elen),
      .cur_bit (scan_bit),
      .last    (scan_last),
      .empty   (scan_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         x_q      <= '0;
         m_q      <= '0;
         r2_q     <= '0;
         xm_q     <= '0;
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: if (start) begin
               x_q   <= in_x;
               m_q   <= in_m;
               r2_q  <= in_r2;
               acc_q <= in_r;
            end
            PRE_WAIT:           if (mm_done) xm_q     <= mm_result;
            SQR_WAIT, MUL_WAIT: if (mm_done) acc_q    <= mm_result;
            POST_WAIT:          if (mm_done) result_q <= mm_result;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next = state;
      scan_load  = 1'b0;
      scan_dec   = 1'b0;
      case (state)
         IDLE: if (start) begin
            state_next = PRE_GO;
            scan_load  = 1'b1;
         end
         PRE_GO:   state_next = PRE_WAIT;
         PRE_WAIT: if (mm_done) state_next = scan_empty ? POST_GO : SQR_GO;
         SQR_GO:   state_next = SQR_WAIT;
         SQR_WAIT: if (mm_done) begin
            if (scan_bit) begin
               state_next = MUL_GO;
            end else if (scan_last) begin
               state_next = POST_GO;
            end else begin
               state_next = SQR_GO;
               scan_dec   = 1'b1;
            end
         end
         MUL_GO:   state_next = MUL_WAIT;
         MUL_WAIT: if (mm_done) begin
            if (scan_last) begin
               state_next = POST_GO;
            end else begin
               state_next = SQR_GO;
               scan_dec   = 1'b1;
            end
         end
         POST_GO:   state_next = POST_WAIT;
         POST_WAIT: if (mm_done) state_next = DONE;
         DONE:      state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // Operands depend only on state and registers that change at mm_done,
   // so they stay fixed for the whole GO/WAIT pair.
   always_comb begin
      mm_a = '0;
      mm_b = '0;
      mm_m = '0;
      case (state)
         PRE_GO, PRE_WAIT: begin
            mm_a = x_q;
            mm_b = r2_q;
            mm_m = m_q;
         end
         SQR_GO, SQR_WAIT: begin
            mm_a = acc_q;
            mm_b = acc_q;
            mm_m = m_q;
         end
         MUL_GO, MUL_WAIT: begin
            mm_a = acc_q;
            mm_b = xm_q;
            mm_m = m_q;
         end
         POST_GO, POST_WAIT: begin
            mm_a = acc_q;
            mm_b = ONE;
            mm_m = m_q;
         end
         default: ;
      endcase
   end

   assign mm_start = is_go(state);
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);
   assign result   = result_q;

endmodule

// File: tb/tb_montgomery_exp_ctrl.sv
// Bench for montgomery_exp_ctrl: behavioural N=8 multiplier with fixed latency,
// directed and random exponentiations against a plain-arithmetic reference.
module tb_montgomery_exp_ctrl;

   localparam int N   = 8;
   localparam int E_W = 8;
   localparam int LW  = $clog2(E_W + 1);
   localparam int L   = 4;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           start = 1'b0;
   logic [N-1:0]   in_x = '0, in_m = '0, in_r = '0, in_r2 = '0;
   logic [E_W-1:0] in_e = '0;
   logic [LW-1:0]  in_elen = '0;
   logic           busy, done, mm_start;
   logic [N-1:0]   result, mm_a, mm_b, mm_m;
   logic [N-1:0]   mm_result = '0;
   logic           mm_done = 1'b0;

   int tests_run = 0;
   int tests_failed = 0;
   int start_cnt = 0;
   int done_cnt = 0;

   montgomery_exp_ctrl #(.N(N), .E_W(E_W), .LW(LW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_x      (in_x),
      .in_e      (in_e),
      .in_elen   (in_elen),
      .in_m      (in_m),
      .in_r      (in_r),
      .in_r2     (in_r2),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .mm_start  (mm_start),
      .mm_a      (mm_a),
      .mm_b      (mm_b),
      .mm_m      (mm_m),
      .mm_result (mm_result),
      .mm_done   (mm_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
      tests_run++;
      assert (got === expv) else begin
         tests_failed++;
         $error("FAIL %s: got %0h required %0h", tag, got, expv);
      end
   endtask

   // a*b*R^-1 mod m with R = 2^N, found by search for R^-1.
   function automatic int mont_ref(input int a, input int b, input int m);
      int rinv = 0;
      for (int k = 1; k < m; k++) if (((k * 256) % m) == 1) rinv = k;
      return (((a * b) % m) * rinv) % m;
   endfunction

   function automatic int ref_pow(input int x, input int val, input int m);
      int res = 1 % m;
      for (int k = 0; k < val; k++) res = (res * x) % m;
      return res;
   endfunction

   // Multiplier model: mm_done pulses L cycles after the mm_start cycle.
   int           mul_cnt = 0;
   logic [N-1:0] mul_a = '0, mul_b = '0, mul_m = '0;
   always @(posedge clk) begin
      mm_done <= (mul_cnt == 1);
      if (mul_cnt == 1) mm_result <= N'(mont_ref(int'(mul_a), int'(mul_b), int'(mul_m)));
      if (mm_start === 1'b1) begin
         mul_cnt <= L - 1;
         mul_a   <= mm_a;
         mul_b   <= mm_b;
         mul_m   <= mm_m;
      end else if (mul_cnt != 0) begin
         mul_cnt <= mul_cnt - 1;
      end
   end

   // Handshake monitor: operand hold and no mm_start while an op is open.
   logic         op_open = 1'b0;
   logic [N-1:0] cap_a, cap_b, cap_m;
   always @(negedge clk) begin
      if (reset !== 1'b0) begin
         op_open = 1'b0;
      end else begin
         if (done === 1'b1) done_cnt++;
         if (op_open) begin
            check("hold_a", mm_a, cap_a);
            check("hold_b", mm_b, cap_b);
            check("hold_m", mm_m, cap_m);
            check("start_in_wait", mm_start, 0);
            if (mm_done === 1'b1) op_open = 1'b0;
         end else if (mm_start === 1'b1) begin
            op_open = 1'b1;
            cap_a = mm_a;
            cap_b = mm_b;
            cap_m = mm_m;
            start_cnt++;
         end
      end
   end

   task automatic set_inputs(input int x, input int e, input int elen, input int m);
      int r;
      r       = 256 % m;
      in_x    = N'(x);
      in_e    = E_W'(e);
      in_elen = LW'(elen);
      in_m    = N'(m);
      in_r    = N'(r);
      in_r2   = N'((r * r) % m);
   endtask

   task automatic run_case(input string tag, input int x, input int e, input int elen,
                           input int m, input bit perturb);
      int eff, val, exp_res, n_ops, exp_k, k, ops0, dones0, busy_bad;
      eff     = (elen > E_W) ? E_W : elen;
      val     = e & ((1 << eff) - 1);
      exp_res = ref_pow(x, val, m);
      n_ops   = 2 + eff + $countones(val);
      exp_k   = 1 + n_ops * (L + 1);
      set_inputs(x, e, elen, m);
      ops0    = start_cnt;
      dones0  = done_cnt;
      start   = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      k        = 1;
      busy_bad = 0;
      while (done !== 1'b1 && k < 400) begin
         if (busy !== 1'b1) busy_bad++;
         if (perturb && k == 8) begin
            start = 1'b1;
            in_x  = N'(x + 1);
            in_e  = ~in_e;
         end
         if (perturb && k == 9) start = 1'b0;
         @(posedge clk); #1;
         k++;
      end
      check({tag, "_done_seen"}, done, 1);
      check({tag, "_latency"}, k, exp_k);
      check({tag, "_result"}, result, exp_res);
      check({tag, "_busy_at_done"}, busy, 1);
      check({tag, "_busy_gap"}, busy_bad, 0);
      check({tag, "_n_ops"}, start_cnt - ops0, n_ops);
      @(posedge clk); #1;
      check({tag, "_done_cleared"}, done, 0);
      check({tag, "_idle"}, busy, 0);
      check({tag, "_result_held"}, result, exp_res);
      check({tag, "_done_pulses"}, done_cnt - dones0, 1);
   endtask

   initial begin
      int k, bad, dones0, ops0, m, x;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_mm_start", mm_start, 0);
      check("rst_mm_a", mm_a, 0);
      check("rst_mm_b", mm_b, 0);
      check("rst_mm_m", mm_m, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      run_case("x2_e5", 2, 5, 3, 13, 1'b0);
      run_case("e0_len0", 7, 0, 0, 13, 1'b0);
      run_case("x0_e3", 0, 3, 2, 13, 1'b0);
      run_case("x12_eff", 12, 8'hFF, 2, 13, 1'b0);
      run_case("perturb", 2, 5, 3, 13, 1'b1);
      run_case("elen_clamp", 5, 8'hA7, 15, 13, 1'b0);
      run_case("full_len", 3, 8'h81, 8, 13, 1'b0);

      // Abort in MUL_WAIT (third op, cycles t+12..t+15), stale mm_done follows.
      set_inputs(2, 5, 3, 13);
      ops0  = start_cnt;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (k = 1; k < 13; k++) begin
         @(posedge clk); #1;
      end
      check("abort_op_index", start_cnt - ops0, 3);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_result", result, 0);
      check("abort_mm_start", mm_start, 0);
      check("abort_mm_a", mm_a, 0);
      check("abort_mm_b", mm_b, 0);
      check("abort_mm_m", mm_m, 0);
      dones0 = done_cnt;
      bad    = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (busy !== 1'b0 || done !== 1'b0 || mm_start !== 1'b0) bad++;
      end
      check("abort_quiet", bad, 0);
      check("abort_no_done", done_cnt - dones0, 0);
      run_case("after_abort", 2, 5, 3, 13, 1'b0);

      for (int i = 0; i < 16; i++) begin
         m = 2 * $urandom_range(1, 127) + 1;
         x = $urandom_range(0, m - 1);
         run_case($sformatf("rand%0d", i), x, $urandom_range(0, 255), $urandom_range(0, 15), m, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
